// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM types and constants (capture FSM states, system clock rate, default loss timeout)
package pwm_pkg;
  typedef enum logic [1:0] {SEEK, HIGH, LOW} pwm_cap_state_t;
  localparam int unsigned PWM_CLK_HZ = 50_000_000;
  localparam int unsigned PWM_DEF_TIMEOUT = 32'd2_000_000;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-FF synchronizer + previous register; d async in, level/rise/fall out, edges suppressed until the pipeline holds real samples after reset
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, prev;
  logic [2:0] fill;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
      fill <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      prev <= s2;
      fill <= {fill[1:0], 1'b1};
    end
  end
  assign level = s2;
  assign rise = fill[2] & s2 & ~prev;
  assign fall = fill[2] & ~s2 & prev;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time/period in clk cycles; clk/reset/pwm_in in, high_count/period_count/meas_valid/signal_lost out
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int unsigned TIMEOUT = PWM_DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_count,
  output logic [WIDTH-1:0] period_count,
  output logic             meas_valid,
  output logic             signal_lost
);
  localparam logic [WIDTH-1:0] TO_LAST = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  pwm_cap_state_t state, state_nx;
  logic [WIDTH-1:0] hcnt, pcnt, hlat, timer;
  logic primed, level, rise, fall, evt, expire, publish;
  sync_edge_detect u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pwm_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );
  always_comb begin
    evt = rise | fall;
    expire = !evt && timer == TO_LAST;
    publish = state == LOW && rise && primed;
    state_nx = expire ? SEEK : rise ? HIGH : (state == HIGH && fall) ? LOW : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEEK;
      hcnt <= '0;
      pcnt <= '0;
      hlat <= '0;
      timer <= '0;
      primed <= 1'b0;
      high_count <= '0;
      period_count <= '0;
      meas_valid <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= (evt || expire) ? '0 : timer + 1'b1;
      hcnt <= rise ? ONE : (state != SEEK && level && hcnt != '1) ? hcnt + 1'b1 : hcnt;
      pcnt <= rise ? ONE : (state != SEEK && pcnt != '1) ? pcnt + 1'b1 : pcnt;
      hlat <= (state == HIGH && fall) ? hcnt : hlat;
      primed <= expire ? 1'b0 : (state == HIGH && fall) ? 1'b1 : primed;
      meas_valid <= publish;
      high_count <= publish ? hlat : high_count;
      period_count <= publish ? pcnt : period_count;
      signal_lost <= publish ? 1'b0 : expire ? 1'b1 : signal_lost;
    end
  end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform: high time and period, in `clk` cycles. It is the receive-side counterpart of the robot's PWM generator, used for RC-receiver channels, servo/ESC feedback and generator loopback self-test. Each complete period produces one-cycle-valid measurements. The block flags loss of signal when no edge arrives within a timeout.

## Interface
Parameters:
- `WIDTH`, 32: width of the internal counters and measurement outputs.
- `TIMEOUT`, 32'd2_000_000: cycles without any edge before signal loss is declared (40 ms at 50 MHz). Must satisfy 1 < TIMEOUT < 2^WIDTH−1.

Ports:
- `clk`, in, 1: 50 MHz system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `pwm_in`, in, 1: asynchronous PWM input.
- `high_count`, out, WIDTH: measured high time of the last complete period, in cycles.
- `period_count`, out, WIDTH: measured rising-to-rising period, in cycles.
- `meas_valid`, out, 1: one-cycle pulse when `high_count`/`period_count` update.
- `signal_lost`, out, 1: level; no valid edge within TIMEOUT cycles.

## Operation
- Input conditioning: 2-FF synchronizer, then a registered previous value. `rise = s2 & ~prev` and `fall = ~s2 & prev`, both computed combinationally from registered bits.
- State machine with states SEEK, HIGH, LOW:
  - SEEK: counters idle, `primed`=0. On `rise`: go to HIGH, `hcnt`=1, `pcnt`=1.
  - HIGH: `hcnt`++ and `pcnt`++ each cycle. On `fall`: go to LOW, `hcnt_latched`=hcnt, `primed`=1.
  - LOW: `pcnt`++ each cycle. On `rise`: go to HIGH, reload `hcnt`=1 and `pcnt`=1.
    - If `primed`, also publish: `period_count`=pcnt, `high_count`=hcnt_latched, `meas_valid`=1, `signal_lost`=0.
- The first rising edge after reset or timeout never publishes. Partial periods are discarded.
- Counters saturate at 2^WIDTH−1 and never wrap.
- Edge timer:
  - Reset to 0 on any `rise`/`fall`; otherwise increments.
  - When it reaches TIMEOUT: go to SEEK, `signal_lost`=1, `primed`=0.
  - Covers stuck-high, stuck-low and no-input cases.
  - In SEEK the timer keeps running. Reaching TIMEOUT again only re-asserts `signal_lost`.
- Outputs hold their last published values while `signal_lost`=1. They are not cleared.
- Simultaneous events: a timeout and an edge in the same cycle resolve in favour of the edge; the timer never expires on an edge cycle. `reset` overrides everything.

## Timing
- Reset values:
  - `high_count`=0, `period_count`=0, `meas_valid`=0, `signal_lost`=0.
  - State SEEK, synchronizer flops 0, all counters 0.
- Latency: `pwm_in` rising before clock edge k gives `meas_valid`=1 in the cycle after edge k+2 (3-cycle latency), when the block is primed.
- Measurement definition: a waveform high for H cycles out of period P (both stable for ≥1 cycle) yields `high_count`=H and `period_count`=P exactly. Both edges see the same synchronizer delay, so the delay cancels.
- Minimum resolvable pulse is 1 cycle high or low. Narrower glitches may be missed.
- `reset` asserted mid-period: next cycle returns to reset state. The first publish comes only after two further rising edges.

## Structure
- Shared package `pwm_pkg`:
  - State enum `pwm_cap_state_t` (SEEK/HIGH/LOW).
  - `PWM_CLK_HZ`=50_000_000.
  - `PWM_DEF_TIMEOUT`.
- Sub-module `sync_edge_detect`: 2-FF synchronizer plus previous register. Outputs `level`, `rise`, `fall`. Reusable for encoder and limit-switch inputs.
- Top module holds the FSM, the `hcnt`/`pcnt`/timer counters and the output registers.

## Test plan
- Steady PWM, period 100, high 25, run 5 periods → first `meas_valid` on the second rise. Every later rise gives `high_count`=25, `period_count`=100, one pulse per period, 3-cycle latency.
- Duty change from 25 to 60 mid-run, period 100 → the period containing the change reports its actual high time. The next reports 60/100.
- Input held high for TIMEOUT+10 cycles (TIMEOUT=1000 in the bench) → `signal_lost`=1 exactly TIMEOUT cycles after the last edge. Outputs hold 25/100. Resuming 25/100 gives `meas_valid` only after two rises, and `signal_lost` clears on that pulse.
- Edge cases: 1-cycle high pulse with period 3 → 1/3. 2-cycle low with period 10 → 8/10.
- `reset` pulsed mid-high-phase → all outputs 0 next cycle. No `meas_valid` until the second full rise after reset.
